// File: rtl/rr_report_packer.sv
// Packs alg_core R-peak results into framed 9-byte packets on a byte stream.
// Results are buffered in a small FIFO so the UART never back-pressures the algorithm.
module rr_report_packer #(
   parameter int unsigned RR_W       = 16,
   parameter int unsigned SN_W       = 32,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic            clk,
   input  logic            nrst,
   input  logic            result_valid,
   input  logic [RR_W-1:0] rr_period,
   input  logic [SN_W-1:0] r_peak_sample_num,
   output logic [7:0]      tx_data,
   output logic            tx_valid,
   input  logic            tx_ready,
   output logic            busy,
   output logic [7:0]      drop_cnt
);

   localparam int unsigned AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW       = $clog2(FIFO_DEPTH + 1);
   localparam logic [7:0]  HDR      = 8'hA5;
   localparam logic [3:0]  LAST_IDX = 4'd8;

   typedef struct packed {
      logic [15:0] rr;
      logic [31:0] sn;
   } entry_t;

   typedef struct packed {
      logic [7:0]  seq;
      logic [15:0] rr;
      logic [31:0] sn;
   } frame_t;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t          state, state_next;
   logic [3:0]      idx, idx_next;
   logic [7:0]      tx_data_next;
   logic            tx_valid_next;
   logic            busy_next;
   logic [7:0]      seq;
   logic [7:0]      load_seq;
   frame_t          frame;
   logic            load;
   logic            seq_inc;

   entry_t          mem [FIFO_DEPTH];
   logic [AW-1:0]   wptr, rptr;
   logic [CW-1:0]   count, count_next;
   logic            fifo_empty, fifo_full;
   logic            wr, pop;
   entry_t          in_entry;

   // Checksum covers bytes 1..7; 8-bit adds wrap naturally to mod 256.
   function automatic logic [7:0] frame_sum(input frame_t f);
      return f.seq + f.rr[15:8] + f.rr[7:0] + f.sn[31:24] + f.sn[23:16]
             + f.sn[15:8] + f.sn[7:0];
   endfunction

   function automatic logic [7:0] frame_byte(input frame_t f, input logic [3:0] i);
      logic [7:0] b;
      b = 8'h00;
      case (i)
         4'd0:    b = HDR;
         4'd1:    b = f.seq;
         4'd2:    b = f.rr[15:8];
         4'd3:    b = f.rr[7:0];
         4'd4:    b = f.sn[31:24];
         4'd5:    b = f.sn[23:16];
         4'd6:    b = f.sn[15:8];
         4'd7:    b = f.sn[7:0];
         4'd8:    b = frame_sum(f);
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   assign in_entry.rr = 16'(rr_period);
   assign in_entry.sn = 32'(r_peak_sample_num);

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == CW'(FIFO_DEPTH));
   // Fullness is judged before any same-cycle pop, so a pop never frees room for this write.
   assign wr         = result_valid && !fifo_full;
   assign pop        = load;
   assign count_next = count + CW'(wr) - CW'(pop);
   assign load_seq   = seq_inc ? (seq + 8'd1) : seq;

   // Next-state and registered-output values.
   always_comb begin
      state_next    = state;
      idx_next      = idx;
      tx_valid_next = tx_valid;
      tx_data_next  = tx_data;
      load          = 1'b0;
      seq_inc       = 1'b0;
      case (state)
         IDLE: begin
            tx_valid_next = 1'b0;
            tx_data_next  = 8'h00;
            if (!fifo_empty) begin
               load          = 1'b1;
               state_next    = SEND;
               idx_next      = 4'd0;
               tx_valid_next = 1'b1;
               tx_data_next  = HDR;
            end
         end
         SEND: begin
            if (tx_ready) begin
               if (idx == LAST_IDX) begin
                  seq_inc = 1'b1;
                  if (!fifo_empty) begin
                     load         = 1'b1;
                     idx_next     = 4'd0;
                     tx_data_next = HDR;
                  end else begin
                     state_next    = IDLE;
                     idx_next      = 4'd0;
                     tx_valid_next = 1'b0;
                     tx_data_next  = 8'h00;
                  end
               end else begin
                  idx_next     = idx + 4'd1;
                  tx_data_next = frame_byte(frame, idx + 4'd1);
               end
            end
         end
      endcase
      busy_next = (state_next == SEND) || (count_next != '0);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Frame register, sequence counter, stream outputs and FIFO bookkeeping.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         idx      <= 4'd0;
         tx_valid <= 1'b0;
         tx_data  <= 8'h00;
         busy     <= 1'b0;
         drop_cnt <= 8'h00;
         seq      <= 8'h00;
         frame    <= '0;
         count    <= '0;
         wptr     <= '0;
         rptr     <= '0;
      end else begin
         idx      <= idx_next;
         tx_valid <= tx_valid_next;
         tx_data  <= tx_data_next;
         busy     <= busy_next;
         count    <= count_next;
         if (seq_inc) begin
            seq <= seq + 8'd1;
         end
         if (load) begin
            frame <= '{seq: load_seq, rr: mem[rptr].rr, sn: mem[rptr].sn};
         end
         if (wr) begin
            wptr <= wptr + AW'(1);
         end
         if (pop) begin
            rptr <= rptr + AW'(1);
         end
         if (result_valid && fifo_full && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
         end
      end
   end

   // Storage is write-once per slot; no reset needed on the data array.
   always_ff @(posedge clk) begin
      if (wr) begin
         mem[wptr] <= in_entry;
      end
   end

endmodule
